// File: rtl/ps2_kbd_display.sv
// PS/2 keyboard receiver: input synchronisers, 11-bit frame checker with a
// stalled-frame timeout, byte FIFO, make/break/extended decoder with
// typematic suppression, and an eight-digit active-low hex display.
module ps2_kbd_display #(
    parameter int FIFO_DEPTH     = 8,
    parameter int COUNT_W        = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               freeze,
    output logic [7:0]         scan_code,
    output logic [7:0]         ascii,
    output logic               key_down,
    output logic               ext,
    output logic [COUNT_W-1:0] press_count,
    output logic               frame_err,
    output logic               overflow,
    output logic [7:0]         seg0,
    output logic [7:0]         seg1,
    output logic [7:0]         seg2,
    output logic [7:0]         seg3,
    output logic [7:0]         seg4,
    output logic [7:0]         seg5,
    output logic [7:0]         seg6,
    output logic [7:0]         seg7
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    // Uppercase ASCII for the mapped scan codes; 0x00 for everything else.
    function automatic logic [7:0] ascii_map(input logic [7:0] c);
        case (c)
            8'h45: ascii_map = 8'h30;  8'h16: ascii_map = 8'h31;
            8'h1E: ascii_map = 8'h32;  8'h26: ascii_map = 8'h33;
            8'h25: ascii_map = 8'h34;  8'h2E: ascii_map = 8'h35;
            8'h36: ascii_map = 8'h36;  8'h3D: ascii_map = 8'h37;
            8'h3E: ascii_map = 8'h38;  8'h46: ascii_map = 8'h39;
            8'h1C: ascii_map = 8'h41;  8'h32: ascii_map = 8'h42;
            8'h21: ascii_map = 8'h43;  8'h23: ascii_map = 8'h44;
            8'h24: ascii_map = 8'h45;  8'h2B: ascii_map = 8'h46;
            8'h34: ascii_map = 8'h47;  8'h33: ascii_map = 8'h48;
            8'h43: ascii_map = 8'h49;  8'h3B: ascii_map = 8'h4A;
            8'h42: ascii_map = 8'h4B;  8'h4B: ascii_map = 8'h4C;
            8'h3A: ascii_map = 8'h4D;  8'h31: ascii_map = 8'h4E;
            8'h44: ascii_map = 8'h4F;  8'h4D: ascii_map = 8'h50;
            8'h15: ascii_map = 8'h51;  8'h2D: ascii_map = 8'h52;
            8'h1B: ascii_map = 8'h53;  8'h2C: ascii_map = 8'h54;
            8'h3C: ascii_map = 8'h55;  8'h2A: ascii_map = 8'h56;
            8'h1D: ascii_map = 8'h57;  8'h22: ascii_map = 8'h58;
            8'h35: ascii_map = 8'h59;  8'h1A: ascii_map = 8'h5A;
            8'h29: ascii_map = 8'h20;  8'h5A: ascii_map = 8'h0D;
            default: ascii_map = 8'h00;
        endcase
    endfunction

    // Active-low glyph, dp (bit 7) always off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 8'hC0;  4'h1: hex_glyph = 8'hF9;
            4'h2: hex_glyph = 8'hA4;  4'h3: hex_glyph = 8'hB0;
            4'h4: hex_glyph = 8'h99;  4'h5: hex_glyph = 8'h92;
            4'h6: hex_glyph = 8'h82;  4'h7: hex_glyph = 8'hF8;
            4'h8: hex_glyph = 8'h80;  4'h9: hex_glyph = 8'h90;
            4'hA: hex_glyph = 8'h88;  4'hB: hex_glyph = 8'h83;
            4'hC: hex_glyph = 8'hC6;  4'hD: hex_glyph = 8'hA1;
            4'hE: hex_glyph = 8'h86;  default: hex_glyph = 8'h8E;
        endcase
    endfunction

    logic          ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic          ps2_data_p0, ps2_data_p1;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] idle_cnt;
    logic [9:0]    rx_sr;
    logic          frame_ok;
    logic          last_bit;
    logic          vld_p0;
    logic [7:0]    byte_p0;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, wr_en;
    logic [7:0]    fifo_dout;

    state_t        state;
    logic          dec_ext, is_make, is_brk, held_match;
    logic [7:0]    scan_nxt, ascii_nxt;
    logic          key_down_nxt, ext_nxt;
    logic [COUNT_W-1:0] count_nxt;
    logic [15:0]   count16;
    logic [7:0]    seg0_nxt, seg1_nxt, seg2_nxt, seg3_nxt;
    logic [7:0]    seg4_nxt, seg5_nxt, seg6_nxt, seg7_nxt;

    // ---- stage p0/p1: synchronised pins; p2 holds the previous clock level
    assign fall     = ps2_clk_p2 & ~ps2_clk_p1;
    assign last_bit = (bit_cnt == 4'd10);
    // start low, stop high (current sample), odd parity over data + parity
    assign frame_ok = ~rx_sr[0] & ps2_data_p1 & (^rx_sr[9:1]);

    // Synchronisers, bit counter, idle timeout and frame verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_clk_p2  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            vld_p0      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_clk_p2  <= ps2_clk_p1;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
            vld_p0      <= fall & last_bit & frame_ok;
            if (fall && last_bit && !frame_ok)
                frame_err <= 1'b1;
            if (fall) begin
                idle_cnt <= '0;
                bit_cnt  <= last_bit ? 4'd0 : bit_cnt + 4'd1;
            end else begin
                if (idle_cnt != IDLE_MAX)
                    idle_cnt <= idle_cnt + 1'b1;
                // a stalled partial frame is silently abandoned
                if (bit_cnt != 4'd0 && idle_cnt == IDLE_MAX)
                    bit_cnt <= 4'd0;
            end
        end
    end

    // Frame shift register (LSB first) and the captured data byte.
    always_ff @(posedge clk) begin
        if (fall) begin
            rx_sr <= {ps2_data_p1, rx_sr[9:1]};
            if (last_bit)
                byte_p0 <= rx_sr[8:1];
        end
    end

    // ---- stage p0 -> FIFO: push of a checked byte
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = ~empty & ~freeze;
    assign wr_en     = vld_p0 & (~full | pop);
    assign fifo_dout = fifo_mem[rd_ptr[AW-1:0]];

    // FIFO pointers and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (vld_p0 && full && !pop)
                overflow <= 1'b1;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_mem[wr_ptr[AW-1:0]] <= byte_p0;
    end

    // ---- FIFO -> decoder: next-state values of the registered outputs
    always_comb begin
        dec_ext    = (state == S_EXT) || (state == S_EXT_BRK);
        is_make    = pop && (((state == S_IDLE) && fifo_dout != 8'hE0 && fifo_dout != 8'hF0) ||
                             ((state == S_EXT) && fifo_dout != 8'hF0));
        is_brk     = pop && ((state == S_BRK) || (state == S_EXT_BRK));
        held_match = key_down && (fifo_dout == scan_code) && (dec_ext == ext);

        scan_nxt     = scan_code;
        ascii_nxt    = ascii;
        key_down_nxt = key_down;
        ext_nxt      = ext;
        count_nxt    = press_count;
        // a make matching the held key is typematic repeat and changes nothing
        if (is_make && !held_match) begin
            scan_nxt     = fifo_dout;
            ascii_nxt    = dec_ext ? 8'h00 : ascii_map(fifo_dout);
            key_down_nxt = 1'b1;
            ext_nxt      = dec_ext;
            count_nxt    = press_count + 1'b1;
        end
        if (is_brk && held_match)
            key_down_nxt = 1'b0;

        count16 = '0;
        count16[COUNT_W-1:0] = count_nxt;
        seg0_nxt = key_down_nxt ? hex_glyph(scan_nxt[3:0]) : 8'hFF;
        seg1_nxt = key_down_nxt ? hex_glyph(scan_nxt[7:4]) : 8'hFF;
        seg2_nxt = (key_down_nxt && ascii_nxt != 8'h00) ? hex_glyph(ascii_nxt[3:0]) : 8'hFF;
        seg3_nxt = (key_down_nxt && ascii_nxt != 8'h00) ? hex_glyph(ascii_nxt[7:4]) : 8'hFF;
        seg4_nxt = hex_glyph(count16[3:0]);
        seg5_nxt = hex_glyph(count16[7:4]);
        seg6_nxt = hex_glyph(count16[11:8]);
        seg7_nxt = hex_glyph(count16[15:12]);
    end

    // Decoder FSM with registered key state and display digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            scan_code   <= '0;
            ascii       <= '0;
            key_down    <= 1'b0;
            ext         <= 1'b0;
            press_count <= '0;
            seg0 <= 8'hFF;  seg1 <= 8'hFF;  seg2 <= 8'hFF;  seg3 <= 8'hFF;
            seg4 <= 8'hC0;  seg5 <= 8'hC0;  seg6 <= 8'hC0;  seg7 <= 8'hC0;
        end else begin
            if (pop) begin
                case (state)
                    S_IDLE:  state <= (fifo_dout == 8'hE0) ? S_EXT :
                                      (fifo_dout == 8'hF0) ? S_BRK : S_IDLE;
                    S_EXT:   state <= (fifo_dout == 8'hF0) ? S_EXT_BRK : S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
            scan_code   <= scan_nxt;
            ascii       <= ascii_nxt;
            key_down    <= key_down_nxt;
            ext         <= ext_nxt;
            press_count <= count_nxt;
            seg0 <= seg0_nxt;  seg1 <= seg1_nxt;  seg2 <= seg2_nxt;  seg3 <= seg3_nxt;
            seg4 <= seg4_nxt;  seg5 <= seg5_nxt;  seg6 <= seg6_nxt;  seg7 <= seg7_nxt;
        end
    end

endmodule
